// File: rtl/seq_mul_4bit_pkg.sv
// Shared constants for the 4x4 shift-add multiplier: FSM state codes, step count, widths.
package seq_mul_4bit_pkg;

  localparam int MUL_WIDTH = 4;
  localparam int MUL_STEPS = 4;
  localparam int CNT_W     = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_mul_4bit_if.sv
// Operand/result bus of the sequential multiplier; abort exists only when MUL_ABORT_EN is defined.
interface seq_mul_4bit_if #(parameter int WIDTH = 4);

  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] PRODUCT;
`ifdef MUL_ABORT_EN
  logic               abort;

  modport master (output start, A, B, abort, input busy, done, PRODUCT);
  modport slave  (input start, A, B, abort, output busy, done, PRODUCT);
`else
  modport master (output start, A, B, input busy, done, PRODUCT);
  modport slave  (input start, A, B, output busy, done, PRODUCT);
`endif

endinterface

// File: rtl/seq_mul_4bit_adder.sv
// 4-bit ripple-carry adder used for the multiplier's add step; Overflow is the final carry-out.
module adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0,
  output logic [3:0] SUM,
  output logic       Overflow
);

  logic [4:0] w_c;

  always_comb begin
    w_c      = '0;
    SUM      = '0;
    w_c[0]   = C0;
    for (int i = 0; i < 4; i++) begin
      SUM[i]   = A[i] ^ B[i] ^ w_c[i];
      w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    Overflow = w_c[4];
  end

endmodule

// File: rtl/seq_mul_4bit.sv
// Sequential shift-add unsigned multiplier, 4b x 4b -> 8b, one partial product per clock.
// Optional MUL_ABORT_EN adds a synchronous abort that cancels an operation in progress.
module seq_mul_4bit
  import seq_mul_4bit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mul_4bit_if.slave  bus
);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;
  logic               w_accept;
  logic               w_abort;
  logic               w_unused_lsb;

  assign w_addend = r_mplr[0] ? r_mcand : '0;

  adder_4bit u_adder (
    .A        (r_acc[2*WIDTH-1:WIDTH]),
    .B        (w_addend),
    .C0       (1'b0),
    .SUM      (w_sum),
    .Overflow (w_carry)
  );

  // Carry re-enters at the top, so the 9-bit sum survives the right shift intact.
  assign w_acc_nxt    = {w_carry, w_sum, r_acc[WIDTH-1:1]};
  assign w_unused_lsb = r_acc[0];

  assign w_last   = (r_cnt == CNT_W'(MUL_STEPS - 1));
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef MUL_ABORT_EN
  assign w_abort = bus.abort && (r_state == S_CALC);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_mcand <= bus.A;
            r_mplr  <= bus.B;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (w_abort) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_acc  <= w_acc_nxt;
            r_mplr <= r_mplr >> 1;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_product <= w_acc_nxt;
              r_state   <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state == S_CALC);
  assign bus.done    = (r_state == S_DONE);
  assign bus.PRODUCT = r_product;

endmodule

// File: tb/tb_seq_mul_4bit.sv
// Self-checking bench for seq_mul_4bit: directed vector table, multi-cycle corner sequences, random ops vs a*b.
module tb_seq_mul_4bit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_mul_4bit_if bus ();

  seq_mul_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
  endtask

  // Called right after issue(); returns the cycle index at which done was seen (0 = never).
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.A     = 4'($urandom);
        bus.B     = 4'($urandom);
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                        input string name);
    int lat, nbusy;
    issue(a, b);
    wait_done(lat, nbusy);
    check({name, "_latency"}, lat, 5);
    check({name, "_busy_cycles"}, nbusy, 4);
    check({name, "_product"}, bus.PRODUCT, exp);
    @(negedge clk);
    check({name, "_done_pulse"}, bus.done, 1'b0);
    check({name, "_held"}, bus.PRODUCT, exp);
  endtask

  initial begin
    int lat, nbusy;
    int done_seen;
    logic [3:0] ra, rb;
    logic [7:0] rexp;

    vecs[0] = '{4'd3,  4'd5,  8'h0F};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd0,  4'd9,  8'h00};
    vecs[3] = '{4'd9,  4'd0,  8'h00};
    vecs[4] = '{4'd7,  4'd6,  8'h2A};
    vecs[5] = '{4'd1,  4'd1,  8'h01};
    vecs[6] = '{4'd15, 4'd1,  8'h0F};
    vecs[7] = '{4'd1,  4'd15, 8'h0F};
    vecs[8] = '{4'd8,  4'd8,  8'h40};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
`ifdef MUL_ABORT_EN
    bus.abort = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_product", bus.PRODUCT, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Start while busy is ignored; start on the done cycle is accepted.
    issue(4'd7, 4'd6);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 2) issue(4'd1, 4'd1);
      if (i == 3) bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check("busy_start_latency", lat, 5);
    check("busy_start_product", bus.PRODUCT, 8'h2A);
    issue(4'd2, 4'd3);
    wait_done(lat, nbusy);
    check("b2b_latency", lat, 5);
    check("b2b_busy_cycles", nbusy, 4);
    check("b2b_product", bus.PRODUCT, 8'h06);
    @(negedge clk);

    // Async reset in the second CALC cycle.
    issue(4'd9, 4'd9);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("midreset_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_done", bus.done, 1'b0);
    check("midreset_product", bus.PRODUCT, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) done_seen = 1;
    end
    check("midreset_no_late_done", done_seen, 0);
    check("midreset_product_after", bus.PRODUCT, 8'h00);

    run_op(4'd3, 4'd5, 8'h0F, "pre_abort");
`ifdef MUL_ABORT_EN
    issue(4'd4, 4'd4);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) done_seen = 1;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_product_held", bus.PRODUCT, 8'h0F);
`else
    run_op(4'd4, 4'd4, 8'h10, "no_abort");
`endif

    for (int k = 0; k < 20; k++) begin
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      rexp = 8'(int'(ra) * int'(rb));
      run_op(ra, rb, rexp, $sformatf("rand%0d_%0d_%0d", k, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
